hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a dedicated cycle, plus direct MTHI/MTLO writes.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10111;
  localparam logic [4:0] OP_DIVU  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               div_zero;
  logic [4:0]         op_r;
  logic               neg_res, neg_rem;
  logic [WIDTH-1:0]   a_raw, mcand, dvsr, quo, rem;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v < 0) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg64(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Request decode
  logic signed [WIDTH-1:0] a_s, b_s;
  logic is_mul, is_div, is_signed, accept;

  assign a_s       = A;
  assign b_s       = B;
  assign is_mul    = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign is_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
  assign accept    = Start && ((state == S_IDLE) || (state == S_DONE));

  // One radix-2 step of each algorithm
  logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
  logic               q_bit;

  assign add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dvsr};
  assign q_bit    = ~rem_diff[WIDTH];

  // Fix-up results; MADD/MSUB accumulate onto HI/LO as they stand at FIX
  logic [2*WIDTH-1:0] prod_fix, mul_res;

  assign prod_fix = cond_neg64(prod, neg_res);

  always_comb begin
    mul_res = prod_fix;
    if (op_r == OP_MADD)      mul_res = {HI, LO} + prod_fix;
    else if (op_r == OP_MSUB) mul_res = {HI, LO} - prod_fix;
  end

  // Datapath registers: no reset, loaded on accept and stepped in RUN
  always_ff @(posedge Clk) begin
    if (accept && (is_mul || is_div)) begin
      op_r    <= Op;
      a_raw   <= A;
      mcand   <= magnitude(a_s, is_signed);
      prod    <= {{WIDTH{1'b0}}, magnitude(b_s, is_signed)};
      quo     <= magnitude(a_s, is_signed);
      dvsr    <= magnitude(b_s, is_signed);
      rem     <= '0;
      neg_res <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_rem <= is_signed && A[WIDTH-1];
    end else if (state == S_RUN) begin
      prod <= {add_sum, prod[WIDTH-1:1]};
      rem  <= q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo  <= {quo[WIDTH-2:0], q_bit};
    end
  end

  // Control and architectural HI/LO
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            if (is_mul || is_div) begin
              state    <= S_RUN;
              cnt      <= '0;
              div_zero <= is_div && (B == '0);
            end else if (Op == OP_MTHI) begin
              HI       <= A;
              div_zero <= 1'b0;
              state    <= S_DONE;
            end else if (Op == OP_MTLO) begin
              LO       <= A;
              div_zero <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        default: begin
          if ((op_r == OP_DIV) || (op_r == OP_DIVU)) begin
            if (div_zero) begin
              LO <= '1;
              HI <= a_raw;
            end else begin
              LO <= cond_neg(quo, neg_res);
              HI <= cond_neg(rem, neg_rem);
            end
          end else begin
            HI <= mul_res[2*WIDTH-1:WIDTH];
            LO <= mul_res[WIDTH-1:0];
          end
          state <= S_DONE;
        end
      endcase
    end
  end

  assign Busy    = (state == S_RUN) || (state == S_FIX);
  assign Done    = (state == S_DONE);
  assign DivZero = (state == S_DONE) && div_zero;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic results, latency, abort and back-to-back issue.
module tb_hilo_muldiv_unit;

  logic        Clk, Rst, Start;
  logic [4:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10111;
  localparam logic [4:0] OP_DIVU  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one Start cycle; returns at the negedge of the cycle after the Start edge
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 5'b00000; A = 32'hDEADBEEF; B = 32'h12345678;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int n;
    start_op(op, a, b);
    wait_done(n);
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(Done), 64'd1);
    chk({tag, " divzero"}, 64'(DivZero), 64'(exp_dz));
    chk({tag, " hi"}, 64'(HI), 64'(exp_hi));
    chk({tag, " lo"}, 64'(LO), 64'(exp_lo));
    @(negedge Clk);
    chk({tag, " done_drop"}, {62'd0, Done, DivZero}, 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] hi_mid, lo_mid;
    Rst = 1'b0; Start = 1'b0; Op = 5'b0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    chk("reset_outputs", {29'd0, Busy, Done, DivZero, HI}, 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    Rst = 1'b1;

    run_op("mult_10_m15", OP_MULT, 32'd10, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFF6A, 1'b0);
    run_op("multu_2_fffe", OP_MULTU, 32'd2, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFC, 1'b0);
    run_op("mult_2_m2", OP_MULT, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0);

    start_op(OP_MTHI, 32'd0, 32'd0);
    chk("mthi_state", {61'd0, Busy, Done, DivZero}, 64'd2);
    chk("mthi_hi", 64'(HI), 64'd0);
    start_op(OP_MTLO, 32'd100, 32'd0);
    chk("mtlo_state", {61'd0, Busy, Done, DivZero}, 64'd2);
    chk("mtlo_lo", 64'(LO), 64'd100);

    // HI/LO must hold during RUN even though operands have changed
    start_op(OP_MADD, 32'd64, 32'd4);
    repeat (10) @(negedge Clk);
    hi_mid = HI; lo_mid = LO;
    chk("madd_hold", {hi_mid, lo_mid}, {32'd0, 32'd100});
    wait_done(n);
    chk("madd_done", 64'(Done), 64'd1);
    chk("madd_result", {HI, LO}, {32'h0, 32'h00000164});

    run_op("msub_1024_1000", OP_MSUB, 32'd1024, 32'd1000, 32'hFFFFFFFF, 32'hFFF06164, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);
    run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    start_op(5'b00000, 32'd55, 32'd66);
    chk("undef_op_ignored", {61'd0, Busy, Done, DivZero}, 64'd0);

    // Start pulse during an in-flight MULT is ignored
    start_op(OP_MULT, 32'd3, 32'd3);
    repeat (3) @(negedge Clk);
    Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0; Op = 5'b0;
    chk("busy_during_ignored_start", 64'(Busy), 64'd1);
    wait_done(n);
    chk("ignored_start_done", 64'(Done), 64'd1);
    chk("ignored_start_result", {HI, LO}, {32'd0, 32'd9});
    @(negedge Clk);
    chk("ignored_start_no_second", {62'd0, Busy, Done}, 64'd0);

    // Asynchronous reset mid-operation
    start_op(OP_MULT, 32'd3, 32'd3);
    repeat (9) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("abort_outputs", {29'd0, Busy, Done, DivZero, HI}, 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    chk("abort_hilo_kept_zero", {HI, LO}, 64'd0);

    // MTLO issued in the DONE cycle of a MULT
    start_op(OP_MULT, 32'd6, 32'd7);
    wait_done(n);
    chk("b2b_mult_done", 64'(Done), 64'd1);
    chk("b2b_mult_result", {HI, LO}, {32'd0, 32'd42});
    Start = 1'b1; Op = OP_MTLO; A = 32'd5;
    @(negedge Clk);
    Start = 1'b0; Op = 5'b0;
    chk("b2b_mtlo_state", {61'd0, Busy, Done, DivZero}, 64'd2);
    chk("b2b_mtlo_result", {HI, LO}, {32'd0, 32'd5});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
